// File: rtl/ksa_gen.sv
// ksa_gen -- RC4-style key-scheduling sequencer driving an external S-box
// memory through a single address/data port with two-cycle read latency.
// Build option: define KSA_GEN_INIT_EN to fill S[i]=i before the schedule;
// without it the schedule runs on whatever the memory already holds.
module ksa_gen #(
    parameter int ADDR_W    = 8,
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   rdy,
    output logic                   done,
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [5:0]             key_len,
    output logic [ADDR_W-1:0]      addr,
    input  logic [ADDR_W-1:0]      rddata,
    output logic [ADDR_W-1:0]      wrdata,
    output logic                   wren
);

    if (ADDR_W < 2 || ADDR_W > 8) begin : g_bad_addr_w
        $error("ksa_gen: ADDR_W must be in 2..8");
    end
    if (KEY_BYTES < 1 || KEY_BYTES > 32) begin : g_bad_key_bytes
        $error("ksa_gen: KEY_BYTES must be in 1..32");
    end

    typedef enum logic [3:0] {
        IDLE, INIT, RD_SI, WT_SI, LD_SI, RD_SJ, WT_SJ, LD_SJ, WR_J, WR_I, FIN
    } state_t;

    localparam logic [5:0]        KB     = 6'(KEY_BYTES);
    localparam logic [8:0]        TOP_SH = 9'(8 * (KEY_BYTES - 1));
    localparam logic [ADDR_W-1:0] LAST   = '1;

    state_t                   state;
    logic [ADDR_W-1:0]        i;
    logic [ADDR_W-1:0]        j;
    logic [ADDR_W-1:0]        si;
    logic [ADDR_W-1:0]        sj;
    logic [8*KEY_BYTES-1:0]   key_r;
    logic [5:0]               klen;
    logic [5:0]               k;       // tracks i mod klen without a divider
    logic [5:0]               klen_eff;
    logic [8:0]               key_sh;
    logic [ADDR_W-1:0]        key_bits;
    logic [ADDR_W-1:0]        j_next;

    // Effective key length, current key byte (MSB byte first) and next j.
    always_comb begin
        // NOTE: every signal here is assigned on every pass, so no latch can form.
        klen_eff = (key_len == 6'd0 || key_len > KB) ? KB : key_len;
        key_sh   = TOP_SH - {k, 3'b000};
        key_bits = ADDR_W'(key_r >> key_sh);
        j_next   = j + rddata + key_bits;
    end

    // Single-process FSM: state, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rdy    <= 1'b1;
            done   <= 1'b0;
            wren   <= 1'b0;
            addr   <= '0;
            wrdata <= '0;
            i      <= '0;
            j      <= '0;
            si     <= '0;
            sj     <= '0;
            k      <= '0;
            key_r  <= '0;
            klen   <= KB;
        end else begin
            // NOTE: non-blocking assignments so every branch sees pre-edge values.
            case (state)
                IDLE: begin
                    if (en) begin
                        key_r <= key;
                        klen  <= klen_eff;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        rdy   <= 1'b0;
                        addr  <= '0;
`ifdef KSA_GEN_INIT_EN
                        wrdata <= '0;
                        wren   <= 1'b1;
                        state  <= INIT;
`else
                        state  <= RD_SI;
`endif
                    end
                end
`ifdef KSA_GEN_INIT_EN
                INIT: begin
                    if (i == LAST) begin
                        i      <= '0;
                        addr   <= '0;
                        wrdata <= '0;
                        wren   <= 1'b0;
                        state  <= RD_SI;
                    end else begin
                        i      <= i + 1'b1;
                        addr   <= i + 1'b1;
                        wrdata <= i + 1'b1;
                    end
                end
`endif
                RD_SI: state <= WT_SI;
                WT_SI: state <= LD_SI;
                LD_SI: begin
                    si    <= rddata;
                    j     <= j_next;
                    addr  <= j_next;
                    state <= RD_SJ;
                end
                RD_SJ: state <= WT_SJ;
                WT_SJ: state <= LD_SJ;
                LD_SJ: begin
                    sj     <= rddata;
                    wrdata <= si;
                    wren   <= 1'b1;
                    state  <= WR_J;
                end
                WR_J: begin
                    addr   <= i;
                    wrdata <= sj;
                    state  <= WR_I;
                end
                WR_I: begin
                    wren   <= 1'b0;
                    wrdata <= '0;
                    i      <= i + 1'b1;
                    k      <= (k == klen - 6'd1) ? 6'd0 : k + 6'd1;
                    if (i == LAST) begin
                        addr  <= '0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        addr  <= i + 1'b1;
                        state <= RD_SI;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    rdy    <= 1'b1;
                    done   <= 1'b0;
                    wren   <= 1'b0;
                    addr   <= '0;
                    wrdata <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ksa_gen.sv
// Bench for ksa_gen: two instances (4-entry and 256-entry S-box), each with a
// two-cycle-latency memory model, an RC4-KSA reference model and a scoreboard.
`timescale 1ns/1ps
module tb_ksa_gen;
`ifdef KSA_GEN_INIT_EN
    localparam bit INIT_ON = 1'b1;
`else
    localparam bit INIT_ON = 1'b0;
`endif
    localparam int NS  = 4;
    localparam int NB  = 256;
    localparam int KBS = 2;
    localparam int KBB = 3;

    typedef struct packed {
        logic [31:0]   lat;
        logic [31:0]   nw;
        logic [2047:0] fin;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        en_s, rdy_s, done_s, wren_s;
    logic [15:0] key_s;
    logic [5:0]  klen_s;
    logic [1:0]  addr_s, rd_s, wd_s, p1_s;
    logic [1:0]  mem_s [NS];

    logic        en_b, rdy_b, done_b, wren_b;
    logic [23:0] key_b;
    logic [5:0]  klen_b;
    logic [7:0]  addr_b, rd_b, wd_b, p1_b;
    logic [7:0]  mem_b [NB];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   busy [2];
    int   acc [2];
    int   dcnt [2];
    int   wcnt [2];
    int   runs [2];
    logic [15:0] wq [2][$];
    exp_t        eq [2][$];

    ksa_gen #(.ADDR_W(2), .KEY_BYTES(KBS)) dut_s (
        .clk(clk), .rst(rst), .en(en_s), .rdy(rdy_s), .done(done_s),
        .key(key_s), .key_len(klen_s), .addr(addr_s), .rddata(rd_s),
        .wrdata(wd_s), .wren(wren_s)
    );

    ksa_gen #(.ADDR_W(8), .KEY_BYTES(KBB)) dut_b (
        .clk(clk), .rst(rst), .en(en_b), .rdy(rdy_b), .done(done_b),
        .key(key_b), .key_len(klen_b), .addr(addr_b), .rddata(rd_b),
        .wrdata(wd_b), .wren(wren_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // S-memories: data appears two cycles after the address.
    always @(posedge clk) begin
        p1_s <= mem_s[addr_s];
        rd_s <= p1_s;
        if (wren_s) mem_s[addr_s] <= wd_s;
        p1_b <= mem_b[addr_b];
        rd_b <= p1_b;
        if (wren_b) mem_b[addr_b] <= wd_b;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_mem(input string name, input logic [2047:0] act,
                             input logic [2047:0] exp, input int n);
        int bad = -1;
        checks++;
        for (int x = n - 1; x >= 0; x--)
            if (act[8*x +: 8] !== exp[8*x +: 8]) bad = x;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: S[%0d]=%0h expected %0h", name, bad,
                     act[8*bad +: 8], exp[8*bad +: 8]);
        end
    endtask

    function automatic logic [2047:0] pack_s();
        logic [2047:0] p = '0;
        for (int x = 0; x < NS; x++) p[8*x +: 8] = 8'(mem_s[x]);
        return p;
    endfunction

    function automatic logic [2047:0] pack_b();
        logic [2047:0] p = '0;
        for (int x = 0; x < NB; x++) p[8*x +: 8] = mem_b[x];
        return p;
    endfunction

    function automatic logic [2047:0] ident(input int n);
        logic [2047:0] p = '0;
        for (int x = 0; x < n; x++) p[8*x +: 8] = 8'(x);
        return p;
    endfunction

    function automatic logic [2047:0] rand_mem(input int n);
        logic [2047:0] p = '0;
        for (int x = 0; x < n; x++) p[8*x +: 8] = 8'($urandom_range(n - 1, 0));
        return p;
    endfunction

    // Plain RC4 key schedule; also records the write sequence the block must issue.
    task automatic model(input int id, input logic [2047:0] start, input logic [255:0] keyv,
                         input int kl, output logic [2047:0] fin);
        int n, kb, len, jj, t;
        int s [256];
        n   = (id == 0) ? NS : NB;
        kb  = (id == 0) ? KBS : KBB;
        len = (kl == 0 || kl > kb) ? kb : kl;
        for (int x = 0; x < n; x++) s[x] = INIT_ON ? x : int'(start[8*x +: 8]);
        if (INIT_ON)
            for (int x = 0; x < n; x++) wq[id].push_back({8'(x), 8'(x)});
        jj = 0;
        for (int x = 0; x < n; x++) begin
            jj = (jj + s[x] + int'(keyv[8*kb-1-8*(x % len) -: 8])) % n;
            wq[id].push_back({8'(jj), 8'(s[x])});
            wq[id].push_back({8'(x), 8'(s[jj])});
            t = s[x]; s[x] = s[jj]; s[jj] = t;
        end
        fin = '0;
        for (int x = 0; x < n; x++) fin[8*x +: 8] = 8'(s[x]);
    endtask

    task automatic issue(input int id, input logic [2047:0] start, input logic [255:0] keyv,
                         input int kl, output logic [2047:0] fin);
        exp_t x;
        int   n;
        n = (id == 0) ? NS : NB;
        model(id, start, keyv, kl, fin);
        x.lat = 32'((INIT_ON ? 9 : 8) * n + 1);
        x.nw  = 32'((INIT_ON ? 3 : 2) * n);
        x.fin = fin;
        eq[id].push_back(x);
    endtask

    task automatic load(input int id, input logic [2047:0] st);
        if (id == 0) for (int x = 0; x < NS; x++) mem_s[x] <= st[8*x +: 2];
        else         for (int x = 0; x < NB; x++) mem_b[x] <= st[8*x +: 8];
    endtask

    task automatic set_key(input int id, input logic [255:0] keyv, input int kl);
        if (id == 0) begin key_s = keyv[15:0]; klen_s = 6'(kl); end
        else         begin key_b = keyv[23:0]; klen_b = 6'(kl); end
    endtask

    task automatic set_en(input int id, input logic e);
        if (id == 0) en_s = e;
        else         en_b = e;
    endtask

    task automatic start_run(input int id, input logic [255:0] keyv, input int kl,
                             input logic [2047:0] start, input bit jitter,
                             output logic [2047:0] fin);
        logic [255:0] junk;
        load(id, start);
        set_key(id, keyv, kl);
        issue(id, start, keyv, kl, fin);
        @(posedge clk); #1 set_en(id, 1'b1);
        @(posedge clk); #1 set_en(id, 1'b0);
        junk = 256'({$urandom, $urandom, $urandom});
        set_key(id, junk, $urandom_range(63, 0));
        if (jitter) begin
            for (int c = 0; c < 20; c++) begin
                @(posedge clk); #1 set_en(id, 1'($urandom));
            end
            set_en(id, 1'b0);
        end
    endtask

    task automatic wait_idle(input int id, input int budget);
        for (int c = 0; c < budget; c++) begin
            @(posedge clk);
            if (!busy[id]) begin
                #1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL timeout[%0d]: still busy after %0d cycles", id, budget);
    endtask

    // Monitor: checks each write against the expected sequence and each
    // completed schedule against the expected latency, done pulse and S contents.
    task automatic mon(input int id, input logic r, input logic d, input logic e,
                       input logic w, input logic [7:0] a, input logic [7:0] wd);
        exp_t x;
        logic [15:0] we;
        if (rst) begin
            if (busy[id] && eq[id].size() > 0) void'(eq[id].pop_front());
            busy[id] = 1'b0;
            wq[id].delete();
            return;
        end
        if (w) begin
            if (busy[id]) wcnt[id]++;
            if (wq[id].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL write_unexpected[%0d]: addr=%0h data=%0h", id, a, wd);
            end else begin
                we = wq[id].pop_front();
                check($sformatf("write[%0d]", id), 32'({a, wd}), 32'(we));
            end
        end
        if (busy[id]) begin
            if (d) dcnt[id]++;
            if (r) begin
                busy[id] = 1'b0;
                runs[id]++;
                if (eq[id].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL run_unexpected[%0d]: no expected run queued", id);
                end else begin
                    x = eq[id].pop_front();
                    check($sformatf("latency[%0d]", id), 32'(cyc - acc[id]), x.lat);
                    check($sformatf("done_pulses[%0d]", id), 32'(dcnt[id]), 32'd1);
                    check($sformatf("write_count[%0d]", id), 32'(wcnt[id]), x.nw);
                    check_mem($sformatf("final_s[%0d]", id),
                              (id == 0) ? pack_s() : pack_b(), x.fin, (id == 0) ? NS : NB);
                end
            end
        end else if (d) begin
            checks++;
            errors++;
            $display("FAIL done_stray[%0d]: done while idle", id);
        end
        if (!busy[id] && r && e) begin
            busy[id] = 1'b1;
            acc[id]  = cyc + 1;
            dcnt[id] = 0;
            wcnt[id] = 0;
        end
    endtask

    always @(negedge clk) mon(0, rdy_s, done_s, en_s, wren_s, 8'(addr_s), 8'(wd_s));
    always @(negedge clk) mon(1, rdy_b, done_b, en_b, wren_b, addr_b, wd_b);

    initial begin
        logic [2047:0] f, f1, f2, fa, fb, st;
        logic [255:0]  kv;
        logic [31:0]   low;
        int            r0, kl;

        en_s = 1'b0; en_b = 1'b0;
        key_s = '0; key_b = '0; klen_s = '0; klen_b = '0;
        load(0, rand_mem(NS));
        load(1, rand_mem(NB));
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy_b",    32'(rdy_b),  32'd1);
        check("rst_done_b",   32'(done_b), 32'd0);
        check("rst_wren_b",   32'(wren_b), 32'd0);
        check("rst_addr_b",   32'(addr_b), 32'd0);
        check("rst_wrdata_b", 32'(wd_b),   32'd0);
        check("rst_rdy_s",    32'(rdy_s),  32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_rdy_s",  32'(rdy_s),  32'd1);
        check("idle_wren_s", 32'(wren_s), 32'd0);

        // 4-entry box, key byte 0x00 with length 1: known result [0,2,3,1].
        start_run(0, 256'h005A, 1, ident(NS), 1'b0, f);
        wait_idle(0, 200);
        fa  = pack_s();
        low = fa[31:0];
        check("directed_s", low, 32'h01030200);

        // 256-entry box: length 3, 0 and oversize must all give the same schedule.
        kv = 256'($urandom_range(24'hFFFFFF, 0));
        start_run(1, kv, 3, ident(NB), 1'b0, f);
        wait_idle(1, 3000);
        fa = pack_b();
        start_run(1, kv, 0, ident(NB), 1'b1, f);
        wait_idle(1, 3000);
        fb = pack_b();
        check_mem("klen0_vs_klen3", fb, fa, NB);
        start_run(1, kv, 40, ident(NB), 1'b0, f);
        wait_idle(1, 3000);

        // Random keys, lengths and starting contents.
        for (int t = 0; t < 8; t++) begin
            kl = ($urandom_range(4, 0) == 0) ? $urandom_range(63, 0) : $urandom_range(KBS, 0);
            start_run(0, 256'($urandom), kl, rand_mem(NS), 1'b1, f);
            wait_idle(0, 200);
        end
        for (int t = 0; t < 2; t++) begin
            start_run(1, 256'($urandom), $urandom_range(KBB, 1), rand_mem(NB), 1'b1, f);
            wait_idle(1, 3000);
        end

        // en held high: second schedule starts as soon as rdy returns.
        st = rand_mem(NS);
        kv = 256'($urandom);
        load(0, st);
        set_key(0, kv, 2);
        issue(0, st, kv, 2, f1);
        issue(0, f1, kv, 2, f2);
        r0 = runs[0];
        @(posedge clk); #1 set_en(0, 1'b1);
        for (int c = 0; c < 200 && runs[0] == r0; c++) @(posedge clk);
        #1 set_en(0, 1'b0);
        if (runs[0] == r0) begin
            checks++;
            errors++;
            $display("FAIL back_to_back: first run never completed");
        end
        wait_idle(0, 200);

        // Reset 500 cycles into a run, then a fresh complete schedule.
        start_run(1, 256'($urandom), 3, rand_mem(NB), 1'b0, f);
        repeat (499) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_rdy",    32'(rdy_b),  32'd1);
        check("midrst_wren",   32'(wren_b), 32'd0);
        check("midrst_done",   32'(done_b), 32'd0);
        check("midrst_addr",   32'(addr_b), 32'd0);
        check("midrst_wrdata", 32'(wd_b),   32'd0);
        @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        start_run(1, 256'($urandom), 2, rand_mem(NB), 1'b0, f);
        wait_idle(1, 3000);

        repeat (4) @(posedge clk);
        check("end_queue_s", 32'(eq[0].size()), 32'd0);
        check("end_queue_b", 32'(eq[1].size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
